// File: rtl/down_counter.sv
// Loadable down-counter / countdown timer with IDLE/RUN/EXPIRED states.
// Ports: clk, rst (async high), load, load_val, dec, clr, ack -> out, underflow, busy, done.
// Optional: define DOWN_COUNTER_AUTO_RELOAD_EN to reload on underflow instead of expiring.
module down_counter #(
  parameter  int MAX_COUNT = 31,
  localparam int BIT_WIDTH = $clog2(MAX_COUNT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [BIT_WIDTH-1:0] load_val,
  input  logic                 dec,
  input  logic                 clr,
  input  logic                 ack,
  output logic [BIT_WIDTH-1:0] out,
  output logic                 underflow,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  localparam logic [BIT_WIDTH-1:0] MAX_V = BIT_WIDTH'(MAX_COUNT);

  state_t               r_state;
  logic [BIT_WIDTH-1:0] r_out;
  logic [BIT_WIDTH-1:0] w_load_sat;
  logic                 w_zero;
  logic                 w_uf;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [BIT_WIDTH-1:0] r_reload;
`endif

  // Compare at the counter width so non power-of-two limits saturate correctly.
  assign w_load_sat = (load_val > MAX_V) ? MAX_V : load_val;
  assign w_zero     = (r_out == '0);
  assign w_uf       = (r_state == S_RUN) & dec & w_zero & ~load & ~clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_out   <= '0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      r_reload <= '0;
`endif
    end else if (clr) begin
      r_state <= S_IDLE;
      r_out   <= '0;
    end else if (load) begin
      r_state <= S_RUN;
      r_out   <= w_load_sat;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      r_reload <= w_load_sat;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_out <= '0;
        end
        S_RUN: begin
          if (dec) begin
            if (!w_zero) begin
              r_out <= r_out - BIT_WIDTH'(1);
            end else begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
              r_out <= r_reload;
`else
              r_state <= S_EXPIRED;
`endif
            end
          end
        end
        S_EXPIRED: begin
          // dec is ignored here; only ack (or clr/load above) leaves.
          if (ack) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_out   <= '0;
        end
      endcase
    end
  end

  assign out       = r_out;
  assign underflow = w_uf;
  assign busy      = (r_state == S_RUN);
  assign done      = (r_state == S_EXPIRED);

endmodule
